vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Single-port framebuffer controller between the VGA timing generator and the 12-bit colour outputs. Shares one synchronous-read RAM between display scan-out (absolute priority), a host write port (valid/ready) and an internal clear engine that fills the buffer with one colour. Scan-out runs at reduced resolution with pixel replication, leaving free RAM slots for writes during active video and blanking.

## Interface
- FB_W, 160: framebuffer width in pixels
- FB_H, 120: framebuffer height in pixels
- SCALE_SH, 2: replication shift; each FB pixel covers 2^SCALE_SH × 2^SCALE_SH screen pixels
- ADDR_W, 15: RAM address width; must satisfy 2^ADDR_W ≥ FB_W*FB_H
- clk_i  input  1  25 MHz pixel clock
- rst_ni  input  1  asynchronous active-low reset
- disp_active_i  input  1  timing generator: visible region
- xcol_i, yrow_i  input  11 each  current screen column/row
- wr_valid_i  input  1  host write request
- wr_ready_o  output  1  host write accepted this cycle when high with wr_valid_i
- wr_addr_i  input  ADDR_W  host linear pixel address (y*FB_W + x)
- wr_data_i  input  12  host colour {R,G,B}
- clear_req_i  input  1  start-clear pulse
- clear_color_i  input  12  fill colour, sampled with clear_req_i
- busy_o  output  1  clear in progress
- clear_done_o  output  1  one-cycle pulse at clear completion
- wr_oob_o  output  1  sticky out-of-range write flag (see Configuration)
- mem_addr_o  output  ADDR_W  RAM address (combinational)
- mem_we_o  output  1  RAM write enable (combinational)
- mem_wdata_o  output  12  RAM write data (combinational)
- mem_rdata_i  input  12  RAM read data, valid one cycle after address
- color_o  output  12  pixel colour to DAC

## Operation
- Display fetch cycle: disp_active_i && xcol_i[SCALE_SH-1:0]==0. Address = (yrow_i>>SCALE_SH)*FB_W + (xcol_i>>SCALE_SH), computed in ADDR_W bits, mem_we_o=0.
- All other cycles are free slots. Priority in free slots: clear engine > host.
- FSM states: IDLE, CLEAR.
- IDLE: wr_ready_o = !fetch cycle. On wr_valid_i && wr_ready_o: mem_addr_o=wr_addr_i, mem_wdata_o=wr_data_i, mem_we_o=1. clear_req_i → CLEAR, counter←0, fill colour latched.
- CLEAR: wr_ready_o=0, busy_o=1. Each free slot writes fill colour to counter address, counter+1. After write to FB_W*FB_H-1 → IDLE; clear_done_o pulses the following cycle. clear_req_i ignored in CLEAR.
- Simultaneous clear_req_i and host transfer in IDLE: host write completes that cycle; CLEAR starts next cycle.
- Scan-out: fetched rdata is registered into color_o and held for 2^SCALE_SH cycles; color_o=0 for any pixel whose disp_active_i was low.
- Idle cycles (no fetch, no write): mem_addr_o holds last fetch address, mem_we_o=0.

## Timing
- Reset values: state IDLE, counter 0, color_o 0, busy_o 0, clear_done_o 0, wr_oob_o 0, pipeline valid bits 0. wr_ready_o follows its combinational rule.
- Scan-out latency: xcol_i/yrow_i at cycle t → color_o valid at t+2; timing generator delays syncs by 2 to match.
- Host write: zero-latency accept; RAM written in the accept cycle. Back-to-back accepts allowed every free slot.
- Clear duration: FB_W*FB_H free slots; with defaults ≥19200 cycles, ~25600 during continuous active video.
- Reset mid-clear: aborts immediately, no clear_done_o, RAM content partial.
- SCALE_SH=0: every active cycle is a fetch; writes only in blanking.

## Configuration
- VGA_FB_BOUNDS_CHECK_EN defined: host writes with wr_addr_i ≥ FB_W*FB_H are accepted (handshake completes) but mem_we_o stays 0 and wr_oob_o sets, cleared only by reset.
- Undefined: address passed to RAM unchanged, wr_oob_o tied 0.

## Test plan
- Reset mid-frame, rst_ni low 3 cycles → color_o=0, busy_o=0, wr_oob_o=0; first active pixel appears 2 cycles after xcol=0, yrow=0.
- Host writes 0xF00 to addr 161 during blanking → scan-out shows 0xF00 at screen x 4..7, y 4..7, color_o 0 elsewhere for a zeroed RAM.
- wr_valid_i held high during active video, SCALE_SH=2 → wr_ready_o low exactly at xcol 0,4,8,…; 3 accepts per 4 cycles, no write on a fetch cycle.
- clear_req_i with 0x0F0 → busy_o high, wr_ready_o 0, all 19200 addresses written 0x0F0, clear_done_o one pulse, then IDLE; second clear_req_i during CLEAR ignored.
- rst_ni asserted after 5000 clear writes → clear_done_o never pulses, busy_o=0 after reset.
- With VGA_FB_BOUNDS_CHECK_EN, write to addr 19200 → handshake completes, mem_we_o=0, wr_oob_o=1 until reset.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display scan-out (absolute priority), clear engine and host writes.
// Optional: define VGA_FB_BOUNDS_CHECK_EN to drop and flag host writes beyond the framebuffer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | host owns free slots; clear_req_i starts a fill
// ST_CLEAR| fill engine owns free slots; host stalled, busy_o high
module vga_fb_arbiter #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2,
    parameter int ADDR_W   = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              disp_active_i,
    input  logic [10:0]       xcol_i,
    input  logic [10:0]       yrow_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [11:0]       wr_data_i,
    input  logic              clear_req_i,
    input  logic [11:0]       clear_color_i,
    output logic              busy_o,
    output logic              clear_done_o,
    output logic              wr_oob_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [11:0]       mem_wdata_o,
    input  logic [11:0]       mem_rdata_i,
    output logic [11:0]       color_o
);

    localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(FB_W * FB_H - 1);
    localparam logic [10:0]       PH_MASK  = 11'((1 << SCALE_SH) - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic [11:0]       r_fill, w_fill_nxt;
    logic              r_done, w_done_nxt;
    logic [ADDR_W-1:0] r_last_faddr;
    logic              r_fetch_d, r_active_d;
    logic [11:0]       r_color;

    logic              w_fetch, w_ready, w_host_xfer, w_host_oob;
    logic [ADDR_W-1:0] w_fy, w_fx, w_fetch_addr;

    assign w_fetch      = disp_active_i && ((xcol_i & PH_MASK) == 11'd0);
    assign w_fy         = ADDR_W'(yrow_i >> SCALE_SH);
    assign w_fx         = ADDR_W'(xcol_i >> SCALE_SH);
    assign w_fetch_addr = w_fy * ADDR_W'(FB_W) + w_fx;

`ifdef VGA_FB_BOUNDS_CHECK_EN
    logic r_oob;

    assign w_host_oob = (wr_addr_i > FB_LAST);

    // Sticky: only reset clears it, so firmware can poll after a burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_oob <= 1'b0;
        end else if (w_host_xfer && w_host_oob) begin
            r_oob <= 1'b1;
        end
    end

    assign wr_oob_o = r_oob;
`else
    assign w_host_oob = 1'b0;
    assign wr_oob_o   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fill_nxt  = r_fill;
        w_done_nxt  = 1'b0;
        w_ready     = 1'b0;
        w_host_xfer = 1'b0;
        mem_addr_o  = w_fetch ? w_fetch_addr : r_last_faddr;
        mem_we_o    = 1'b0;
        mem_wdata_o = 12'h000;

        case (r_state)
            ST_IDLE: begin
                w_ready     = !w_fetch;
                w_host_xfer = wr_valid_i && !w_fetch;
                if (w_host_xfer) begin
                    mem_addr_o  = wr_addr_i;
                    mem_wdata_o = wr_data_i;
                    mem_we_o    = !w_host_oob;
                end
                if (clear_req_i) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                    w_fill_nxt  = clear_color_i;
                end
            end
            ST_CLEAR: begin
                if (!w_fetch) begin
                    mem_addr_o  = r_cnt;
                    mem_wdata_o = r_fill;
                    mem_we_o    = 1'b1;
                    if (r_cnt == FB_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_fill  <= 12'h000;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fill  <= w_fill_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Two-stage scan-out: address at t, RAM data at t+1, registered colour at t+2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_d    <= 1'b0;
            r_active_d   <= 1'b0;
            r_last_faddr <= '0;
            r_color      <= 12'h000;
        end else begin
            r_fetch_d  <= w_fetch;
            r_active_d <= disp_active_i;
            if (w_fetch) begin
                r_last_faddr <= w_fetch_addr;
            end
            if (r_fetch_d) begin
                r_color <= mem_rdata_i;
            end else if (!r_active_d) begin
                r_color <= 12'h000;
            end
        end
    end

    assign wr_ready_o   = w_ready;
    assign busy_o       = (r_state == ST_CLEAR);
    assign clear_done_o = r_done;
    assign color_o      = r_color;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural synchronous-read RAM.
// Bounds-check expectations follow VGA_FB_BOUNDS_CHECK_EN when it is defined.
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 15;
    localparam int FB_N   = 19200;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              disp_active_i;
    logic [10:0]       xcol_i, yrow_i;
    logic              wr_valid_i, wr_ready_o;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [11:0]       wr_data_i;
    logic              clear_req_i;
    logic [11:0]       clear_color_i;
    logic              busy_o, clear_done_o, wr_oob_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [11:0]       mem_wdata_o;
    logic [11:0]       mem_rdata_i;
    logic [11:0]       color_o;

    int checks = 0;
    int errors = 0;

    logic [11:0] ram [0:(1<<ADDR_W)-1];

    always #20 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= ram[mem_addr_o];
    end

    vga_fb_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .disp_active_i(disp_active_i),
        .xcol_i(xcol_i), .yrow_i(yrow_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .clear_req_i(clear_req_i), .clear_color_i(clear_color_i),
        .busy_o(busy_o), .clear_done_o(clear_done_o), .wr_oob_o(wr_oob_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .color_o(color_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [11:0] exp_px(input int x, input int y, input logic act);
        if (!act) return 12'h000;
        if ((x / 4) == 1 && (y / 4) == 1) return 12'hF00;
        if ((x / 4) == 0 && (y / 4) == 0) return 12'h123;
        return 12'h000;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; disp_active_i = 1'b1; xcol_i = 11'd5; yrow_i = 11'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (color_o !== 12'h000 || busy_o !== 1'b0 || wr_oob_o !== 1'b0 || clear_done_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: color=%h busy=%b oob=%b done=%b, want 000/0/0/0",
                         color_o, busy_o, wr_oob_o, clear_done_o);
            end
        end
        checks++;
        if (wr_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", wr_ready_o);
        end
        disp_active_i = 1'b0; rst_ni = 1'b1;
        step();
        disp_active_i = 1'b1; xcol_i = 11'd0; yrow_i = 11'd0;
        step();
        checks++;
        if (color_o !== 12'h000) begin
            errors++; $display("FAIL first_px_t1: got %h want 000", color_o);
        end
        xcol_i = 11'd1;
        step();
        checks++;
        if (color_o !== 12'h123) begin
            errors++; $display("FAIL first_px_t2: got %h want 123", color_o);
        end
        xcol_i = 11'd2;
        step();
        disp_active_i = 1'b0;
        step();
        step();
        checks++;
        if (color_o !== 12'h000) begin
            errors++; $display("FAIL blank_px: got %h want 000", color_o);
        end
    endtask

    task automatic test_host_write_scan();
        logic [11:0] prev_exp;
        logic        have_prev;
        disp_active_i = 1'b0;
        wr_valid_i = 1'b1; wr_addr_i = 15'd161; wr_data_i = 12'hF00;
        #1;
        checks++;
        if (wr_ready_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 15'd161 || mem_wdata_o !== 12'hF00) begin
            errors++;
            $display("FAIL host_write: ready=%b we=%b addr=%0d data=%h, want 1/1/161/F00",
                     wr_ready_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        step();
        wr_valid_i = 1'b0;
        have_prev = 1'b0;
        prev_exp = 12'h000;
        for (int y = 0; y < 12; y++) begin
            for (int k = 0; k < 20; k++) begin
                disp_active_i = (k < 16);
                xcol_i = 11'(k); yrow_i = 11'(y);
                step();
                if (have_prev) begin
                    checks++;
                    if (color_o !== prev_exp) begin
                        errors++;
                        $display("FAIL scan y=%0d k=%0d: got %h want %h", y, k, color_o, prev_exp);
                    end
                end
                prev_exp  = exp_px(k, y, k < 16);
                have_prev = 1'b1;
            end
        end
        disp_active_i = 1'b0;
    endtask

    task automatic test_ready_pattern();
        int accepts;
        accepts = 0;
        wr_valid_i = 1'b1; wr_addr_i = 15'd5000; wr_data_i = 12'h000;
        yrow_i = 11'd8;
        for (int x = 0; x < 16; x++) begin
            disp_active_i = 1'b1; xcol_i = 11'(x);
            #1;
            checks++;
            if (wr_ready_o !== ((x % 4) != 0) || mem_we_o !== wr_ready_o) begin
                errors++;
                $display("FAIL ready_pattern x=%0d: ready=%b we=%b", x, wr_ready_o, mem_we_o);
            end
            if ((x % 4) == 0) begin
                checks++;
                if (mem_addr_o !== 15'(320 + x / 4)) begin
                    errors++;
                    $display("FAIL fetch_addr x=%0d: got %0d want %0d", x, mem_addr_o, 320 + x / 4);
                end
            end
            if (wr_ready_o === 1'b1) accepts++;
            step();
        end
        checks++;
        if (accepts !== 12) begin
            errors++; $display("FAIL accept_count: got %0d want 12", accepts);
        end
        disp_active_i = 1'b0; wr_valid_i = 1'b0;
        #1;
        checks++;
        if (mem_addr_o !== 15'd323 || mem_we_o !== 1'b0) begin
            errors++; $display("FAIL idle_hold: addr=%0d we=%b want 323/0", mem_addr_o, mem_we_o);
        end
        step();
    endtask

    task automatic test_oob();
        disp_active_i = 1'b0;
        wr_valid_i = 1'b1; wr_addr_i = 15'd19200; wr_data_i = 12'hFFF;
        #1;
`ifdef VGA_FB_BOUNDS_CHECK_EN
        checks++;
        if (wr_ready_o !== 1'b1 || mem_we_o !== 1'b0) begin
            errors++; $display("FAIL oob_write: ready=%b we=%b want 1/0", wr_ready_o, mem_we_o);
        end
        step();
        wr_addr_i = 15'd10; wr_data_i = 12'h000;
        step();
        wr_valid_i = 1'b0;
        checks++;
        if (wr_oob_o !== 1'b1) begin
            errors++; $display("FAIL oob_sticky: got %b want 1", wr_oob_o);
        end
`else
        checks++;
        if (wr_ready_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 15'd19200) begin
            errors++;
            $display("FAIL oob_passthru: ready=%b we=%b addr=%0d want 1/1/19200", wr_ready_o, mem_we_o, mem_addr_o);
        end
        step();
        wr_valid_i = 1'b0;
        checks++;
        if (wr_oob_o !== 1'b0) begin
            errors++; $display("FAIL oob_flag: got %b want 0", wr_oob_o);
        end
`endif
        step();
    endtask

    task automatic test_clear();
        int busy_cnt, done_cnt, bad, low_at;
        logic done_at_low;
        busy_cnt = 0; done_cnt = 0; bad = 0; low_at = -1; done_at_low = 1'b0;
        disp_active_i = 1'b0;
        clear_req_i = 1'b1; clear_color_i = 12'h0F0;
        wr_valid_i = 1'b1; wr_addr_i = 15'd300; wr_data_i = 12'hABC;
        #1;
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 15'd300 || mem_wdata_o !== 12'hABC || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_and_host: we=%b addr=%0d data=%h busy=%b want 1/300/ABC/0",
                     mem_we_o, mem_addr_o, mem_wdata_o, busy_o);
        end
        step();
        clear_req_i = 1'b0;
        for (int n = 0; n < 30000; n++) begin
            wr_valid_i    = (n == 0);
            disp_active_i = (n >= 20 && n < 36);
            xcol_i        = 11'(n - 20); yrow_i = 11'd0;
            clear_req_i   = (n == 100);
            clear_color_i = (n == 100) ? 12'h00F : 12'h0F0;
            #1;
            if (n == 0) begin
                checks++;
                if (busy_o !== 1'b1 || wr_ready_o !== 1'b0 || mem_addr_o !== 15'd0 || mem_wdata_o !== 12'h0F0) begin
                    errors++;
                    $display("FAIL clear_start: busy=%b ready=%b addr=%0d data=%h want 1/0/0/0F0",
                             busy_o, wr_ready_o, mem_addr_o, mem_wdata_o);
                end
            end
            if (n == 24) begin
                checks++;
                if (mem_we_o !== 1'b0) begin
                    errors++; $display("FAIL clear_fetch_slot: we=%b want 0", mem_we_o);
                end
            end
            if (busy_o === 1'b1 && low_at < 0) busy_cnt++;
            if (clear_done_o === 1'b1) done_cnt++;
            if (busy_o !== 1'b1 && low_at < 0) begin
                low_at = n;
                done_at_low = clear_done_o;
            end
            if (low_at >= 0 && n >= low_at + 5) break;
            step();
        end
        clear_req_i = 1'b0; wr_valid_i = 1'b0; disp_active_i = 1'b0;
        checks++;
        if (busy_cnt !== 19204) begin
            errors++; $display("FAIL clear_cycles: got %0d want 19204", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1 || done_at_low !== 1'b1) begin
            errors++; $display("FAIL clear_done: pulses=%0d at_end=%b want 1/1", done_cnt, done_at_low);
        end
        checks++;
        if (busy_o !== 1'b0 || wr_ready_o !== 1'b1) begin
            errors++; $display("FAIL clear_idle: busy=%b ready=%b want 0/1", busy_o, wr_ready_o);
        end
        for (int a = 0; a < FB_N; a++) if (ram[a] !== 12'h0F0) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL clear_fill: %0d words differ from 0F0", bad);
        end
        step();
    endtask

    task automatic test_reset_mid_clear();
        int done_seen;
        done_seen = 0;
        disp_active_i = 1'b0;
        clear_req_i = 1'b1; clear_color_i = 12'h555;
        step();
        clear_req_i = 1'b0;
        repeat (5000) step();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || mem_we_o !== 1'b0) begin
            errors++; $display("FAIL abort: busy=%b we=%b want 0/0", busy_o, mem_we_o);
        end
        repeat (3) begin
            step();
            if (clear_done_o === 1'b1) done_seen++;
        end
        rst_ni = 1'b1;
        repeat (30) begin
            step();
            if (clear_done_o === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || busy_o !== 1'b0 || wr_oob_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: done_pulses=%0d busy=%b oob=%b want 0/0/0", done_seen, busy_o, wr_oob_o);
        end
        checks++;
        if (ram[4999] !== 12'h555 || ram[5000] !== 12'h0F0) begin
            errors++;
            $display("FAIL abort_partial: ram[4999]=%h ram[5000]=%h want 555/0F0", ram[4999], ram[5000]);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 12'h000;
        ram[0] = 12'h123;
        rst_ni = 1'b0; disp_active_i = 1'b0; xcol_i = '0; yrow_i = '0;
        wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        clear_req_i = 1'b0; clear_color_i = '0;
        test_reset();
        test_host_write_scan();
        test_ready_pattern();
        test_oob();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
